// File: rtl/siacore_pkg.sv
// Shared types and constants for the siacore work scheduler.
// Holds the FSM state encoding, header field bounds and the nonce byte-order helper.
package siacore_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        RUN      = 2'd2,
        REPORT   = 2'd3
    } sched_state_t;

    localparam int NONCE_LO = 256;
    localparam int NONCE_HI = 287;
    localparam int HDR_W    = 640;
    localparam int TGT_W    = 64;

    // Header carries the nonce little-endian; cores report it in native order.
    function automatic logic [31:0] byteswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/siacore_sched_arb.sv
// Lowest-index-wins priority encoder over the per-core found pulses.
// Purely combinational; returns hit flag, winning index and that core's nonce.
module siacore_sched_arb #(
    parameter int NCORES = 4,
    parameter int IW     = 2
) (
    input  logic [NCORES-1:0]    found,
    input  logic [NCORES*32-1:0] nonce,
    output logic                 hit,
    output logic [IW-1:0]        idx,
    output logic [31:0]          sel_nonce
);

    always_comb begin
        hit       = 1'b0;
        idx       = '0;
        sel_nonce = '0;
        // Scan high to low so the last match written is the lowest index.
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (found[i]) begin
                hit       = 1'b1;
                idx       = IW'(i);
                sel_nonce = nonce[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/siacore_sched.sv
// Splits one mining job into NCORES equal nonce slices, dispatches them and returns one result.
// Optional statistics counters are built when SIACORE_SCHED_STATS_EN is defined.
module siacore_sched
    import siacore_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int IW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [HDR_W-1:0]     work_in,
    input  logic [TGT_W-1:0]     target_in,
    input  logic                 work_valid,
    output logic                 work_ready,
    output logic [HDR_W-1:0]     core_work,
    output logic [TGT_W-1:0]     core_target,
    output logic [NCORES-1:0]    core_valid,
    input  logic [NCORES-1:0]    core_busy,
    input  logic [NCORES-1:0]    core_found,
    input  logic [NCORES*32-1:0] core_nonce,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_nonce,
    output logic [IW-1:0]        res_core,
`ifdef SIACORE_SCHED_STATS_EN
    output logic [31:0]          stat_found,
    output logic [15:0]          stat_drop,
`endif
    output logic                 res_miss
);

    localparam int LOG2N = $clog2(NCORES);

    sched_state_t          state_reg, state_next;
    logic [IW-1:0]         d_reg, d_next;
    logic [31:0]           start_reg, start_next;
    logic [1:0]            run_cnt_reg, run_cnt_next;
    logic                  idle_cnt_reg, idle_cnt_next;
    logic [NCORES-1:0]     core_valid_reg, core_valid_next;
    logic [HDR_W-1:0]      core_work_reg, core_work_next;
    logic [TGT_W-1:0]      core_target_reg, core_target_next;
    logic                  res_valid_reg, res_valid_next;
    logic [31:0]           res_nonce_reg, res_nonce_next;
    logic [IW-1:0]         res_core_reg, res_core_next;
    logic                  res_miss_reg, res_miss_next;

    logic [NCORES-1:0]     live_mask;
    logic [NCORES-1:0]     found_live;
    logic                  arb_hit;
    logic [IW-1:0]         arb_idx;
    logic [31:0]           arb_nonce;
    logic                  take_hit;

    // Slice base: start plus d times (2^32 / NCORES), wrapping modulo 2^32.
    function automatic logic [31:0] slice_base(input logic [31:0] s, input logic [IW-1:0] d);
        logic [63:0] off;
        off = 64'(d) << (32 - LOG2N);
        return s + off[31:0];
    endfunction

    // A core may only win once its start pulse has gone out in an earlier cycle.
    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_live
            assign live_mask[gi] = (state_reg == RUN) ||
                                   ((state_reg == DISPATCH) && (int'(d_reg) > gi));
        end
    endgenerate

    assign found_live = core_found & live_mask;

    siacore_sched_arb #(
        .NCORES (NCORES),
        .IW     (IW)
    ) u_arb (
        .found     (found_live),
        .nonce     (core_nonce),
        .hit       (arb_hit),
        .idx       (arb_idx),
        .sel_nonce (arb_nonce)
    );

    always_comb begin
        state_next       = state_reg;
        d_next           = d_reg;
        start_next       = start_reg;
        run_cnt_next     = '0;
        idle_cnt_next    = 1'b0;
        core_valid_next  = '0;
        core_work_next   = core_work_reg;
        core_target_next = core_target_reg;
        res_valid_next   = res_valid_reg;
        res_nonce_next   = res_nonce_reg;
        res_core_next    = res_core_reg;
        res_miss_next    = res_miss_reg;
        take_hit         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (work_valid) begin
                    // Slice 0 starts at the job's own nonce, so the header goes out unchanged.
                    core_work_next   = work_in;
                    core_target_next = target_in;
                    start_next       = byteswap32(work_in[NONCE_HI:NONCE_LO]);
                    d_next           = '0;
                    core_valid_next  = NCORES'(1);
                    state_next       = DISPATCH;
                end
            end
            DISPATCH: begin
                if (arb_hit) begin
                    take_hit = 1'b1;
                end else if (d_reg == IW'(NCORES - 1)) begin
                    state_next = RUN;
                end else begin
                    d_next          = d_reg + IW'(1);
                    core_valid_next = NCORES'(1) << d_next;
                    core_work_next[NONCE_HI:NONCE_LO] = byteswap32(slice_base(start_reg, d_next));
                end
            end
            RUN: begin
                if (arb_hit) begin
                    take_hit = 1'b1;
                end else begin
                    run_cnt_next = (run_cnt_reg == 2'd2) ? 2'd2 : run_cnt_reg + 2'd1;
                    // Busy flags are only trusted from the third RUN cycle onward.
                    if ((run_cnt_reg == 2'd2) && (core_busy == '0)) begin
                        if (idle_cnt_reg) begin
                            res_valid_next = 1'b1;
                            res_miss_next  = 1'b1;
                            res_nonce_next = '0;
                            res_core_next  = '0;
                            state_next     = REPORT;
                        end else begin
                            idle_cnt_next = 1'b1;
                        end
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (take_hit) begin
            res_valid_next = 1'b1;
            res_miss_next  = 1'b0;
            res_nonce_next = arb_nonce;
            res_core_next  = arb_idx;
            state_next     = REPORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            d_reg           <= '0;
            start_reg       <= '0;
            run_cnt_reg     <= '0;
            idle_cnt_reg    <= 1'b0;
            core_valid_reg  <= '0;
            core_work_reg   <= '0;
            core_target_reg <= '0;
            res_valid_reg   <= 1'b0;
            res_nonce_reg   <= '0;
            res_core_reg    <= '0;
            res_miss_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            d_reg           <= d_next;
            start_reg       <= start_next;
            run_cnt_reg     <= run_cnt_next;
            idle_cnt_reg    <= idle_cnt_next;
            core_valid_reg  <= core_valid_next;
            core_work_reg   <= core_work_next;
            core_target_reg <= core_target_next;
            res_valid_reg   <= res_valid_next;
            res_nonce_reg   <= res_nonce_next;
            res_core_reg    <= res_core_next;
            res_miss_reg    <= res_miss_next;
        end
    end

    assign work_ready  = (state_reg == IDLE);
    assign core_valid  = core_valid_reg;
    assign core_work   = core_work_reg;
    assign core_target = core_target_reg;
    assign res_valid   = res_valid_reg;
    assign res_nonce   = res_nonce_reg;
    assign res_core    = res_core_reg;
    assign res_miss    = res_miss_reg;

`ifdef SIACORE_SCHED_STATS_EN
    logic [31:0] stat_found_reg, stat_found_next;
    logic [15:0] stat_drop_reg, stat_drop_next;
    logic [4:0]  n_live, n_raw, drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        n_live = '0;
        n_raw  = '0;
        for (int i = 0; i < NCORES; i++) begin
            n_live = n_live + 5'(found_live[i]);
            n_raw  = n_raw + 5'(core_found[i]);
        end
        // Pulses outside an active job are stale; losers of arbitration are dropped.
        if ((state_reg == IDLE) || (state_reg == REPORT)) begin
            drop_inc = n_raw;
        end else if (take_hit) begin
            drop_inc = n_live - 5'd1;
        end else begin
            drop_inc = '0;
        end
        drop_sum        = {1'b0, stat_drop_reg} + 17'(drop_inc);
        stat_drop_next  = drop_sum[16] ? '1 : drop_sum[15:0];
        stat_found_next = (take_hit && (stat_found_reg != '1)) ? stat_found_reg + 32'd1
                                                               : stat_found_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_found_reg <= '0;
            stat_drop_reg  <= '0;
        end else begin
            stat_found_reg <= stat_found_next;
            stat_drop_reg  <= stat_drop_next;
        end
    end

    assign stat_found = stat_found_reg;
    assign stat_drop  = stat_drop_reg;
`endif

endmodule

// File: tb/tb_siacore_sched.sv
// Self-checking bench for siacore_sched (NCORES=4): vector table, corner sequences, random jobs.
// Expected slice bases and winners come from a division-based model of the nonce partition.
`timescale 1ns/1ps
module tb_siacore_sched;

    localparam int NCORES = 4;
    localparam int IW     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [639:0]         work_in;
    logic [63:0]          target_in;
    logic                 work_valid;
    logic                 work_ready;
    logic [639:0]         core_work;
    logic [63:0]          core_target;
    logic [NCORES-1:0]    core_valid;
    logic [NCORES-1:0]    core_busy;
    logic [NCORES-1:0]    core_found;
    logic [NCORES*32-1:0] core_nonce;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_nonce;
    logic [IW-1:0]        res_core;
    logic                 res_miss;
`ifdef SIACORE_SCHED_STATS_EN
    logic [31:0]          stat_found;
    logic [15:0]          stat_drop;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    siacore_sched #(.NCORES(NCORES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .work_in     (work_in),
        .target_in   (target_in),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .core_work   (core_work),
        .core_target (core_target),
        .core_valid  (core_valid),
        .core_busy   (core_busy),
        .core_found  (core_found),
        .core_nonce  (core_nonce),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_nonce   (res_nonce),
        .res_core    (res_core),
`ifdef SIACORE_SCHED_STATS_EN
        .stat_found  (stat_found),
        .stat_drop   (stat_drop),
`endif
        .res_miss    (res_miss)
    );

    typedef struct {
        logic [31:0]  field;
        bit           miss;
        logic [3:0]   fmask;
        int           cyc;
        int           hold;
        logic [127:0] nonces;
        logic [31:0]  f1;
        logic [31:0]  f3;
        logic [31:0]  exp_nonce;
        logic [1:0]   exp_core;
        bit           exp_miss;
    } vec_t;

    vec_t tab[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        logic [31:0] y;
        y = {<<8{x}};
        return y;
    endfunction

    // Nonce space divided into NCORES equal slices, computed with plain modular arithmetic.
    function automatic logic [31:0] model_base(input logic [31:0] start, input int i);
        longint unsigned span, s;
        span = 64'd4294967296 / NCORES;
        s    = (longint'(start) + longint'(i) * span) % 64'd4294967296;
        return s[31:0];
    endfunction

    task automatic do_job(input string tag, input logic [31:0] field, input bit miss,
                          input logic [3:0] fmask, input int cyc, input int hold,
                          input logic [127:0] nonces, input bit use_tab,
                          input logic [31:0] tf1, input logic [31:0] tf3,
                          input logic [31:0] exp_nonce, input logic [IW-1:0] exp_core,
                          input bit exp_miss);
        logic [639:0] hdr;
        logic [63:0]  tgt;
        logic [31:0]  start;
        int           waited;
        int           m;
        bit           seen;
`ifdef SIACORE_SCHED_STATS_EN
        logic [15:0]  drop0;
        logic [31:0]  found0;
`endif
        for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
        hdr[287:256] = field;
        tgt   = {$urandom, $urandom};
        start = bswap(field);
        core_busy  = '1;
        work_in    = hdr;
        target_in  = tgt;
        work_valid = 1'b1;
        check($sformatf("%s.ready_idle", tag), work_ready, 1);
        tick();
        work_valid = 1'b0;
        work_in    = ~hdr;
        target_in  = ~tgt;
        for (int d = 0; d < NCORES; d++) begin
            check($sformatf("%s.valid_d%0d", tag, d), core_valid, 64'(1) << d);
            check($sformatf("%s.field_d%0d", tag, d), core_work[287:256], bswap(model_base(start, d)));
            check($sformatf("%s.hdr_keep_d%0d", tag, d),
                  {core_work[639:288], core_work[255:0]} == {hdr[639:288], hdr[255:0]}, 1);
            check($sformatf("%s.target_d%0d", tag, d), core_target, tgt);
            check($sformatf("%s.ready_disp_d%0d", tag, d), work_ready, 0);
            if (use_tab && d == 1) check($sformatf("%s.tab_f1", tag), core_work[287:256], tf1);
            if (use_tab && d == 3) check($sformatf("%s.tab_f3", tag), core_work[287:256], tf3);
            tick();
        end
        check($sformatf("%s.valid_run", tag), core_valid, 0);
        for (int c = 1; c < cyc; c++) begin
            check($sformatf("%s.novalid_c%0d", tag, c), res_valid, 0);
            tick();
        end
`ifdef SIACORE_SCHED_STATS_EN
        drop0  = stat_drop;
        found0 = stat_found;
`endif
        if (!miss) begin
            core_found = fmask;
            core_nonce = nonces;
            tick();
            core_found = '0;
            core_nonce = {$urandom, $urandom, $urandom, $urandom};
`ifdef SIACORE_SCHED_STATS_EN
            check($sformatf("%s.stat_drop", tag), stat_drop, drop0 + 16'($countones(fmask) - 1));
            check($sformatf("%s.stat_found", tag), stat_found, found0 + 1);
`endif
        end else begin
            core_busy = '0;
            waited = 0;
            seen   = 0;
            while (!seen && waited < 20) begin
                tick();
                waited++;
                if (res_valid) seen = 1;
            end
            m = (cyc > 3) ? cyc : 3;
            check($sformatf("%s.miss_latency", tag), waited, m + 2 - cyc);
        end
        for (int h = 0; h <= hold; h++) begin
            check($sformatf("%s.res_valid_h%0d", tag, h), res_valid, 1);
            check($sformatf("%s.res_nonce_h%0d", tag, h), res_nonce, exp_nonce);
            check($sformatf("%s.res_core_h%0d", tag, h), res_core, exp_core);
            check($sformatf("%s.res_miss_h%0d", tag, h), res_miss, exp_miss);
            check($sformatf("%s.ready_rep_h%0d", tag, h), work_ready, 0);
            if (h < hold) begin
                core_found = 4'($urandom);
                core_nonce = {$urandom, $urandom, $urandom, $urandom};
                tick();
            end
        end
        core_found = '0;
        res_ready  = 1'b1;
        tick();
        res_ready  = 1'b0;
        check($sformatf("%s.res_valid_done", tag), res_valid, 0);
        check($sformatf("%s.ready_done", tag), work_ready, 1);
        $display("job %s: field=%08h core=%0d nonce=%08h miss=%0d", tag, field, res_core, res_nonce, res_miss);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [639:0] hdr;
        logic [3:0]   mask, low;
        logic [127:0] nz;
        logic [31:0]  fld, en;
        logic [IW-1:0] ec;
        bit           ms;
        int           idx;

        tab[0] = '{32'h10000000, 1'b0, 4'b0100, 1, 0, {32'h0, 32'h80000123, 64'h0},
                   32'h10000040, 32'h100000C0, 32'h80000123, 2'd2, 1'b0};
        tab[1] = '{32'h01234567, 1'b0, 4'b1010, 2, 0, {32'hBBBB0003, 32'h0, 32'hAAAA0001, 32'h0},
                   32'h012345A7, 32'h01234527, 32'hAAAA0001, 2'd1, 1'b0};
        tab[2] = '{32'h00000000, 1'b1, 4'b0000, 1, 1, 128'h0,
                   32'h00000040, 32'h000000C0, 32'h0, 2'd0, 1'b1};
        tab[3] = '{32'hF0FFFFFF, 1'b0, 4'b1000, 3, 5, {32'h12345678, 96'h0},
                   32'hF0FFFF3F, 32'hF0FFFFBF, 32'h12345678, 2'd3, 1'b0};
        tab[4] = '{32'hDEADBEEF, 1'b1, 4'b0000, 5, 2, 128'h0,
                   32'hDEADBE2F, 32'hDEADBEAF, 32'h0, 2'd0, 1'b1};
        tab[5] = '{32'h10000000, 1'b0, 4'b0001, 4, 1, {96'h0, 32'hFFFFFFFF},
                   32'h10000040, 32'h100000C0, 32'hFFFFFFFF, 2'd0, 1'b0};

        rst_n      = 1'b0;
        work_in    = '0;
        target_in  = '0;
        work_valid = 1'b0;
        core_busy  = '0;
        core_found = '0;
        core_nonce = '0;
        res_ready  = 1'b0;
        tick();
        tick();
        check("rst.work_ready", work_ready, 1);
        check("rst.res_valid", res_valid, 0);
        check("rst.res_miss", res_miss, 0);
        check("rst.res_nonce", res_nonce, 0);
        check("rst.res_core", res_core, 0);
        check("rst.core_valid", core_valid, 0);
        check("rst.core_work_zero", core_work == '0, 1);
        check("rst.core_target", core_target, 0);
        rst_n = 1'b1;
        tick();
        check("rst.released_ready", work_ready, 1);

        for (int i = 0; i < 6; i++) begin
            do_job($sformatf("tab%0d", i), tab[i].field, tab[i].miss, tab[i].fmask, tab[i].cyc,
                   tab[i].hold, tab[i].nonces, 1'b1, tab[i].f1, tab[i].f3,
                   tab[i].exp_nonce, tab[i].exp_core, tab[i].exp_miss);
        end

        // Found while still dispatching: core 0 is live at d=2, core 3 is not yet started.
        for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
        hdr[287:256] = 32'h10000000;
        work_in = hdr;
        core_busy = '1;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        tick();
        tick();
        check("dfound.valid_d2", core_valid, 4'b0100);
        core_found = 4'b1001;
        core_nonce = {32'h33333333, 64'h0, 32'h0BAD0000};
        tick();
        core_found = '0;
        check("dfound.res_valid", res_valid, 1);
        check("dfound.res_core", res_core, 0);
        check("dfound.res_nonce", res_nonce, 32'h0BAD0000);
        check("dfound.res_miss", res_miss, 0);
        check("dfound.no_more_dispatch", core_valid, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("dfound.ready_after", work_ready, 1);
        $display("job dfound: core=%0d nonce=%08h", res_core, res_nonce);

        // Reset pulsed in the middle of dispatch, then a stale found after release.
        work_in = hdr;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        tick();
        tick();
        check("rstmid.valid_d2", core_valid, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("rstmid.core_valid", core_valid, 0);
        check("rstmid.core_work_zero", core_work == '0, 1);
        check("rstmid.core_target", core_target, 0);
        check("rstmid.work_ready", work_ready, 1);
        check("rstmid.res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_found = 4'b0010;
        core_nonce = {$urandom, $urandom, $urandom, $urandom};
        tick();
        core_found = '0;
        check("rstmid.stale_res_valid", res_valid, 0);
        check("rstmid.stale_ready", work_ready, 1);
        check("rstmid.stale_core_valid", core_valid, 0);
        tick();
        check("rstmid.stale_res_valid2", res_valid, 0);
        $display("job rstmid: reset during dispatch, stale found ignored");
        do_job("after_rst", 32'h44332211, 1'b0, 4'b0110, 2, 0,
               {32'h0, 32'h22220002, 32'h11110001, 32'h0}, 1'b0, 32'h0, 32'h0,
               32'h11110001, 2'd1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            fld  = $urandom;
            mask = 4'($urandom_range(1, 15));
            ms   = ($urandom_range(0, 3) == 0);
            nz   = {$urandom, $urandom, $urandom, $urandom};
            low  = mask & (~mask + 4'd1);
            idx  = $clog2(low);
            if (ms) begin
                en = '0;
                ec = '0;
            end else begin
                en = nz[32*idx +: 32];
                ec = IW'(idx);
            end
            do_job($sformatf("rnd%0d", r), fld, ms, mask, $urandom_range(1, 5),
                   $urandom_range(0, 3), nz, 1'b0, 32'h0, 32'h0, en, ec, ms);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
